addend_recover: RTL
===================

ADDEND_RECOVER -- requirements
Module: addend_recover

Interface
REQ-001 SHALL have parameter WIDTH, default 12: addend width; must be even.
REQ-002 SHALL have parameter SPLIT, default WIDTH/2: bit position of the pipeline cut between stage 1 and stage 2.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: an input pair is offered.
REQ-006 SHALL have port in_ready, output, 1: the block accepts the pair this cycle.
REQ-007 SHALL have port in_sum, input, WIDTH+1: the full sum word, carry-out at MSB, as produced by the team's WIDTH-bit adder.
REQ-008 SHALL have port in_a, input, WIDTH: the known addend.
REQ-009 SHALL have port out_valid, output, 1: a result is presented.
REQ-010 SHALL have port out_ready, input, 1: the downstream consumer takes the result.
REQ-011 SHALL have port out_b, output, WIDTH: the recovered addend, in_sum - in_a, truncated to WIDTH bits.
REQ-012 SHALL have port out_err, output, 1: the range-violation flag, per REQ-023.

Function
REQ-013 SHALL complete a transfer on an input edge only when in_valid and in_ready are both 1.
REQ-014 SHALL complete a transfer on an output edge only when out_valid and out_ready are both 1.
REQ-015 SHALL use a two-stage pipeline.
- Stage 1 registers low = in_sum[SPLIT-1:0] - in_a[SPLIT-1:0] and its borrow bit.
- Stage 1 also registers the upper slices of in_sum and in_a.
REQ-016 SHALL, in stage 2, register the upper result as in_sum[WIDTH:SPLIT] - {1'b0, in_a[WIDTH-1:SPLIT]} - borrow, giving WIDTH-SPLIT+1 bits.
REQ-017 SHALL have a latency of 2 cycles from input transfer to out_valid, with out_ready held at 1.
REQ-018 SHALL sustain a throughput of one transfer per cycle with out_ready held at 1.
REQ-019 SHALL give each stage a valid bit, and SHALL let a stage load when it is empty or when its contents advance in the same cycle.
REQ-020 SHALL drive in_ready = !s1_valid | !s2_valid | out_ready, combinationally, with no dependence on in_valid.
REQ-021 SHALL, while out_valid=1 and out_ready=0, hold out_b and out_err stable, and SHALL accept at most one further input, into stage 1.
REQ-022 SHALL deliver results in the order the inputs were accepted, with no loss and no duplication.
REQ-023 SHALL set out_err=1 when the true difference in_sum - in_a is below 0, or above 2^WIDTH-1.
REQ-024 SHALL, in the out_err=1 case, still drive out_b as the low WIDTH bits of the modular difference.
REQ-025 SHALL, in the same cycle as an output transfer with a new stage-1 entry advancing, replace stage 2's contents with no bubble.

Reset
REQ-026 SHALL, on rst_n low, immediately clear both stage valid bits, giving out_valid=0, in_ready=1, out_b=0 and out_err=0.
REQ-027 SHALL discard any in-flight data when reset asserts mid-operation.
REQ-028 SHALL produce no output transfer in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL honour macro ADDEND_RECOVER_RANGE_CHECK_EN.
- Defined: out_err follows REQ-023; a sign bit and an upper-overflow check are kept in stage 2.
- Undefined: out_err is tied to 0; the check logic is absent; out_b and its timing are unchanged.

Structure
REQ-030 SHALL place ADDEND_WIDTH (12), ADDEND_SPLIT (6) and the typedef addend_t in a shared package, addend_pkg, alongside the adder's constants.
REQ-031 SHALL place typedef sum_t (WIDTH+1 bits) in the same package, addend_pkg.
REQ-032 SHALL put the per-stage slice subtraction in one sub-module, addend_sub_slice: a parameterised N-bit subtract taking a borrow-in and producing a borrow-out, instantiated once per stage.

Verification
REQ-033 SHALL cover: in_sum=0x0579, in_a=0x123 -> after 2 cycles out_b=0x456, out_err=0.
REQ-034 SHALL cover: in_sum=0x0040, in_a=0x001 -> out_b=0x03F, out_err=0 (borrow crosses the split).
REQ-035 SHALL cover three range cases, with the macro defined:
- in_sum=0x0005, in_a=0x006 -> out_b=0xFFF, out_err=1.
- in_sum=0x1000, in_a=0x000 -> out_b=0x000, out_err=1.
- in_sum=0x1FFE, in_a=0xFFF -> out_b=0xFFF, out_err=0.
REQ-036 SHALL cover: with the macro undefined, in_sum=0x0005, in_a=0x006 -> out_err=0, out_b=0xFFF.
REQ-037 SHALL cover backpressure: 4 back-to-back inputs, with out_ready=0 for cycles 2-6.
- in_ready drops after 2 pairs are accepted.
- All 4 results emerge in order once out_ready=1.
REQ-038 SHALL cover reset mid-stream: rst_n pulsed low with both stages full -> out_valid=0 at once, and the old data never appears.

Source files
------------

// File: rtl/addend_pkg.sv
// Shared widths and word types for the adder and the addend-recovery pipeline.
package addend_pkg;

    localparam int ADDER_WIDTH     = 12;
    localparam int ADDER_SUM_WIDTH = ADDER_WIDTH + 1;

    localparam int ADDEND_WIDTH = ADDER_WIDTH;
    localparam int ADDEND_SPLIT = ADDEND_WIDTH / 2;

    typedef logic [ADDEND_WIDTH-1:0] addend_t;
    typedef logic [ADDEND_WIDTH:0]   sum_t;

endpackage

// File: rtl/addend_sub_slice.sv
// N-bit subtract slice, x - y - borrow_in, with borrow chained to the next slice.
module addend_sub_slice #(
    parameter int N = 6
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         borrow_in,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    // The extra top bit of the widened difference is the borrow.
    assign {borrow_out, diff} = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, borrow_in};

endmodule

// File: rtl/addend_recover.sv
// Recovers b = sum - a through a two-stage split subtractor with valid/ready flow.
// Macro ADDEND_RECOVER_RANGE_CHECK_EN enables the out_err range flag.
module addend_recover
    import addend_pkg::*;
#(
    parameter int WIDTH = ADDEND_WIDTH,
    parameter int SPLIT = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_sum,
    input  logic [WIDTH-1:0] in_a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_b,
    output logic             out_err
);

    localparam int HW = WIDTH - SPLIT;

    logic             s1_valid, s2_valid;
    logic             s1_load, s2_load;
    logic [SPLIT-1:0] s1_low, s2_low;
    logic             s1_borrow;
    logic [HW:0]      s1_sum_hi;
    logic [HW-1:0]    s1_a_hi, s2_hi;

    logic [SPLIT-1:0] low_d;
    logic             borrow_d;
    logic [HW:0]      hi_d;
    logic             sign_d;

    assign in_ready = !s1_valid || !s2_valid || out_ready;
    assign s1_load  = in_valid && in_ready;
    assign s2_load  = s1_valid && (!s2_valid || out_ready);

    addend_sub_slice #(.N(SPLIT)) u_lo (
        .x          (in_sum[SPLIT-1:0]),
        .y          (in_a[SPLIT-1:0]),
        .borrow_in  (1'b0),
        .diff       (low_d),
        .borrow_out (borrow_d)
    );

    // Upper slice keeps the carry-out bit, so it is one bit wider than the addend slice.
    addend_sub_slice #(.N(HW + 1)) u_hi (
        .x          (s1_sum_hi),
        .y          ({1'b0, s1_a_hi}),
        .borrow_in  (s1_borrow),
        .diff       (hi_d),
        .borrow_out (sign_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_low    <= '0;
            s1_borrow <= 1'b0;
            s1_sum_hi <= '0;
            s1_a_hi   <= '0;
            s2_low    <= '0;
            s2_hi     <= '0;
        end else begin
            if (s1_load) begin
                s1_low    <= low_d;
                s1_borrow <= borrow_d;
                s1_sum_hi <= in_sum[WIDTH:SPLIT];
                s1_a_hi   <= in_a[WIDTH-1:SPLIT];
            end
            if (s2_load) begin
                s2_low <= s1_low;
                s2_hi  <= hi_d[HW-1:0];
            end
            s1_valid <= s1_load || (s1_valid && !s2_load);
            s2_valid <= s2_load || (s2_valid && !out_ready);
        end
    end

`ifdef ADDEND_RECOVER_RANGE_CHECK_EN
    logic s2_err;

    // Negative when the full-width subtract borrows; too large when bit WIDTH survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_err <= 1'b0;
        end else if (s2_load) begin
            s2_err <= sign_d || hi_d[HW];
        end
    end

    assign out_err = s2_err;
`else
    logic unused_range;
    assign unused_range = &{1'b0, sign_d, hi_d[HW]};
    assign out_err      = 1'b0;
`endif

    assign out_valid = s2_valid;
    assign out_b     = {s2_hi, s2_low};

endmodule
